// File: rtl/case_3_pkg.sv
// Shared definitions for the frame accumulator with output saturation.
//   state_t          : controller states (accumulate / present result)
//   DEF_*            : default widths and frame length
//   sat_max/sat_min  : signed clamp bounds for a result of a given width
package case_3_pkg;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    localparam int DEF_DIN_WIDTH  = 13;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_DOUT_WIDTH = 16;
    localparam int DEF_LEN        = 16;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    localparam longint DEF_SAT_MAX = sat_max(DEF_DOUT_WIDTH);
    localparam longint DEF_SAT_MIN = sat_min(DEF_DOUT_WIDTH);

endpackage

// File: rtl/case_3_sat_24_16.sv
// Combinational signed clamp from the accumulator width to the result width.
//   sum  : signed accumulator value (ACC_WIDTH)
//   dout : sum clamped to the signed DOUT_WIDTH range
//   sat  : 1 when clamping changed the value
module case_3_sat_24_16
    import case_3_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH
) (
    input  logic signed [ACC_WIDTH-1:0]  sum,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         sat
);

    localparam logic signed [ACC_WIDTH-1:0] HI = ACC_WIDTH'(sat_max(DOUT_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] LO = ACC_WIDTH'(sat_min(DOUT_WIDTH));

    // Returns {sat, clamped value}
    function automatic logic [DOUT_WIDTH:0] clamp(input logic signed [ACC_WIDTH-1:0] s);
        logic [DOUT_WIDTH:0] r;
        if (s > HI) begin
            r = {1'b1, HI[DOUT_WIDTH-1:0]};
        end else if (s < LO) begin
            r = {1'b1, LO[DOUT_WIDTH-1:0]};
        end else begin
            r = {1'b0, s[DOUT_WIDTH-1:0]};
        end
        return r;
    endfunction

    logic [DOUT_WIDTH:0] res;

    always_comb begin
        res  = clamp(sum);
        sat  = res[DOUT_WIDTH];
        dout = res[DOUT_WIDTH-1:0];
    end

endmodule

// File: rtl/case_3_acc_sat_13_16.sv
// Frame accumulator: sums LEN signed products, then presents the saturated
// frame sum on a valid/ready output before starting the next frame.
//   ap_clk, ap_rst_n   : clock, asynchronous active-low reset
//   din, din_vld/rdy   : signed product input stream
//   dout, dout_vld/rdy : saturated frame sum output
//   sat                : dout was clamped
module case_3_acc_sat_13_16
    import case_3_pkg::*;
#(
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int DOUT_WIDTH = DEF_DOUT_WIDTH,
    parameter int LEN        = DEF_LEN
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0]  din,
    input  logic                         din_vld,
    output logic                         din_rdy,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_vld,
    input  logic                         dout_rdy,
    output logic                         sat
);

    localparam int CNT_W = $clog2(LEN);

    // Elaboration-time guards: frame length range and no accumulator wrap
    if (LEN < 2 || LEN > 2048) begin : g_len_check
        $error("LEN must be in 2..2048");
    end
    if (ACC_WIDTH < DIN_WIDTH + $clog2(LEN)) begin : g_acc_check
        $error("ACC_WIDTH too small for DIN_WIDTH and LEN");
    end
    if (ACC_WIDTH < DOUT_WIDTH) begin : g_dout_check
        $error("ACC_WIDTH must be at least DOUT_WIDTH");
    end

    state_t                         state, state_nxt;
    logic signed [ACC_WIDTH-1:0]    acc, acc_nxt, acc_sum;
    logic        [CNT_W-1:0]        cnt, cnt_nxt;
    logic signed [DOUT_WIDTH-1:0]   dout_nxt, clamp_val;
    logic                           sat_nxt, clamp_sat;
    logic                           accept, last_beat;

    // Ready/valid come straight from the state register, so there is no
    // combinational path from dout_rdy to din_rdy.
    assign din_rdy   = (state == ST_ACC);
    assign dout_vld  = (state == ST_OUT);
    assign accept    = din_vld & din_rdy;
    assign last_beat = accept && (cnt == CNT_W'(LEN - 1));
    assign acc_sum   = acc + {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};

    // The clamp sees the sum including the current beat, so the last beat
    // lands in dout on the same edge that enters OUT.
    case_3_sat_24_16 #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DOUT_WIDTH (DOUT_WIDTH)
    ) u_sat (
        .sum  (acc_sum),
        .dout (clamp_val),
        .sat  (clamp_sat)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        sat_nxt   = sat;
        case (state)
            ST_ACC: begin
                if (last_beat) begin
                    state_nxt = ST_OUT;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    dout_nxt  = clamp_val;
                    sat_nxt   = clamp_sat;
                end else if (accept) begin
                    acc_nxt = acc_sum;
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_OUT: begin
                if (dout_rdy) begin
                    state_nxt = ST_ACC;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_ACC;
            acc   <= '0;
            cnt   <= '0;
            dout  <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            dout  <= dout_nxt;
            sat   <= sat_nxt;
        end
    end

endmodule

// File: tb/tb_case_3_acc_sat_13_16.sv
// Bench for case_3_acc_sat_13_16: directed frames, a frame-level reference
// model and a per-cycle compare process, plus literal expectations.
module tb_case_3_acc_sat_13_16;

    localparam int LEN = 16;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic signed [12:0] din = '0;
    logic               din_vld = 1'b0;
    logic               din_rdy;
    logic signed [15:0] dout;
    logic               dout_vld;
    logic               dout_rdy = 1'b1;
    logic               sat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_cnt = 0;

    case_3_acc_sat_13_16 dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_rdy  (din_rdy),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .sat      (sat)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp16(input int s);
        if (s > 32767) return 32767;
        if (s < -32768) return -32768;
        return s;
    endfunction

    // Frame-level reference: a running sum of accepted beats; after LEN of
    // them the clamped sum is pending until the downstream takes it.
    bit m_busy = 1'b0;
    int m_cnt = 0;
    int m_sum = 0;
    int m_dout = 0;
    bit m_sat = 1'b0;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_sum  <= 0;
        end else if (!m_busy) begin
            if (din_vld) begin
                if (m_cnt + 1 == LEN) begin
                    m_busy <= 1'b1;
                    m_dout <= clamp16(m_sum + int'(din));
                    m_sat  <= (clamp16(m_sum + int'(din)) != m_sum + int'(din));
                    m_cnt  <= 0;
                    m_sum  <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                    m_sum <= m_sum + int'(din);
                end
            end
        end else if (dout_rdy) begin
            m_busy <= 1'b0;
        end
    end

    always @(posedge ap_clk) begin
        cyc <= cyc + 1;
        if (ap_rst_n && dout_vld && dout_rdy) out_cnt <= out_cnt + 1;
    end

    // Per-cycle compare against the model
    always @(negedge ap_clk) begin
        if (ap_rst_n) begin
            check("din_rdy", din_rdy, !m_busy);
            check("dout_vld", dout_vld, m_busy);
            if (m_busy) begin
                check("dout", dout, m_dout);
                check("sat", sat, m_sat);
            end
        end
    end

    // Present one beat and hold it until the edge that accepts it
    task automatic beat(input int v);
        bit rdy_before;
        bit done;
        done = 1'b0;
        din = 13'(v);
        din_vld = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy_before = din_rdy;
            @(posedge ap_clk);
            #1;
            if (rdy_before) done = 1'b1;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL beat_timeout: got no accept, expected accept within 50 cycles");
        end
    endtask

    task automatic idle(input int n);
        din_vld = 1'b0;
        repeat (n) begin
            @(posedge ap_clk);
            #1;
        end
    endtask

    task automatic frame_done(input string name, input int exp_dout, input bit exp_sat);
        din_vld = 1'b0;
        check({name, "_latency_vld"}, dout_vld, 1);
        check({name, "_dout"}, dout, exp_dout);
        check({name, "_sat"}, sat, exp_sat);
    endtask

    int t0;
    int outs0;

    initial begin
        // Reset held across clock edges
        repeat (3) @(posedge ap_clk);
        #1;
        check("rst_din_rdy", din_rdy, 1);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_dout", dout, 0);
        check("rst_sat", sat, 0);
        ap_rst_n = 1'b1;

        // 16 x 100 back-to-back
        for (int i = 0; i < LEN; i++) beat(100);
        frame_done("f100", 1600, 1'b0);

        // Positive clamp
        for (int i = 0; i < LEN; i++) beat(4095);
        frame_done("fpos", 32767, 1'b1);

        // Negative clamp
        for (int i = 0; i < LEN; i++) beat(-4096);
        frame_done("fneg", -32768, 1'b1);

        // Alternating +7/-3 with a bubble between beats
        for (int i = 0; i < LEN; i++) begin
            beat((i % 2 == 0) ? 7 : -3);
            if (i == 0) t0 = cyc;
            if (i != LEN - 1) idle(1);
        end
        frame_done("falt", 32, 1'b0);
        check("falt_cycles", cyc - t0, 2 * (LEN - 1));

        // Back-pressure: result held, pending input not consumed
        for (int i = 0; i < LEN - 1; i++) beat(5);
        dout_rdy = 1'b0;
        beat(5);
        frame_done("fhold", 80, 1'b0);
        din = 13'(9);
        din_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge ap_clk);
            #1;
            check("hold_dout", dout, 80);
            check("hold_din_rdy", din_rdy, 0);
        end
        dout_rdy = 1'b1;
        @(posedge ap_clk);
        #1;
        check("hold_release_rdy", din_rdy, 1);
        for (int i = 0; i < LEN; i++) beat(9);
        frame_done("fafter", 144, 1'b0);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) beat(1000);
        din_vld = 1'b0;
        outs0 = out_cnt;
        ap_rst_n = 1'b0;
        #1;
        check("mid_rst_dout_vld", dout_vld, 0);
        check("mid_rst_dout", dout, 0);
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        for (int i = 0; i < LEN; i++) beat(1);
        frame_done("frst", 16, 1'b0);
        @(posedge ap_clk);
        #1;
        check("frst_outputs", out_cnt - outs0, 1);

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
